// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter and read sequencer between the LSU (A) and
// loader/debug port (B) for the single-port data memory.
// Ports: clk, reset (sync, active-high); per requester X in {a,b}:
//   x_req/x_we/x_addr/x_wdata in, x_gnt/x_rvalid/x_rdata/x_err out;
//   memory side: mem_addr/mem_wdata/mem_we out, mem_rdata in.
module dmem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int BASE   = 64,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic S_IDLE    = 1'b0;
  localparam logic S_RD_WAIT = 1'b1;

  localparam logic [ADDR_W-1:0] LO = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] HI = ADDR_W'(BASE + DEPTH - 1);

  logic              state;
  logic              last_b;
  logic              rd_own_b;
  logic [ADDR_W-1:0] rd_addr;

  logic              idle;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              legal;

  // No grants while reset is held, so memory is never written then.
  assign idle  = (state == S_IDLE) && !reset;
  // last_b=1 means B was granted last, so A wins a tie.
  assign a_gnt = idle && a_req && (!b_req || last_b);
  assign b_gnt = idle && b_req && (!a_req || !last_b);

  assign any_gnt   = a_gnt || b_gnt;
  assign sel_we    = b_gnt ? b_we    : a_we;
  assign sel_addr  = b_gnt ? b_addr  : a_addr;
  assign sel_wdata = b_gnt ? b_wdata : a_wdata;
  assign legal     = (sel_addr >= LO) && (sel_addr <= HI);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (any_gnt) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      mem_we    = sel_we && legal;
    end else if (state == S_RD_WAIT) begin
      mem_addr  = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      last_b   <= 1'b1;
      rd_own_b <= 1'b0;
      rd_addr  <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= a_gnt && !legal;
      b_err    <= b_gnt && !legal;
      unique case (state)
        S_IDLE: begin
          if (any_gnt) begin
            last_b <= b_gnt;
            if (legal && !sel_we) begin
              state    <= S_RD_WAIT;
              rd_addr  <= sel_addr;
              rd_own_b <= b_gnt;
            end
          end
        end
        S_RD_WAIT: begin
          // Memory output is valid now for the address sampled last cycle.
          state <= S_IDLE;
          if (rd_own_b) begin
            b_rdata  <= mem_rdata;
            b_rvalid <= 1'b1;
          end else begin
            a_rdata  <= mem_rdata;
            a_rvalid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: transaction-level reference model,
// behavioural memory, directed scenarios plus randomized traffic.
module tb_dmem_port_arbiter;

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wd;
    int         gap;
  } txn_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Behavioural single-port memory: registered read, write blocks read.
  logic [7:0] dev_mem [256];
  logic [7:0] dev_rdata;
  bit         inited = 1'b0;
  assign mem_rdata = dev_rdata;
  always @(posedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= 8'(i * 7 + 13);
      inited <= 1'b1;
    end else if (mem_we) begin
      dev_mem[mem_addr] <= mem_wdata;
    end else begin
      dev_rdata <= dev_mem[mem_addr];
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [256];
  int         cyc = 0;
  bit         last_b;
  int         free_at;
  logic [7:0] rd_addr_m;
  int         rv_at [2];
  int         err_at [2];
  logic [7:0] rv_data [2];
  logic [7:0] exp_rdata [2];
  bit         chk_on = 1'b0;

  txn_t       qa[$], qb[$];
  int         wait_c [2];
  bit         rst_v;

  int         glog[$], gcyc[$];
  int         rva_cyc, n_arv, n_berr;
  int         checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [7:0] a);
    return (a >= 8'd64) && (a <= 8'd127);
  endfunction

  task automatic step();
    bit ra, rb, busy;
    int win;
    txn_t t;
    @(posedge clk);
    #1;
    reset = rst_v;
    ra = 0;
    rb = 0;
    if (qa.size() > 0) begin
      if (wait_c[0] > 0) wait_c[0]--;
      else ra = 1;
    end
    if (qb.size() > 0) begin
      if (wait_c[1] > 0) wait_c[1]--;
      else rb = 1;
    end
    a_req = ra; b_req = rb;
    a_we = 0; a_addr = 0; a_wdata = 0;
    b_we = 0; b_addr = 0; b_wdata = 0;
    if (ra) begin
      a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wd;
    end
    if (rb) begin
      b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wd;
    end
    @(negedge clk);
    if (a_gnt) begin glog.push_back(0); gcyc.push_back(cyc); end
    if (b_gnt) begin glog.push_back(1); gcyc.push_back(cyc); end
    if (a_rvalid) begin rva_cyc = cyc; n_arv++; end
    if (b_err) n_berr++;
    if (chk_on) begin
      for (int r = 0; r < 2; r++)
        if (rv_at[r] == cyc) exp_rdata[r] = rv_data[r];
      chk("a_rvalid", a_rvalid, rv_at[0] == cyc);
      chk("b_rvalid", b_rvalid, rv_at[1] == cyc);
      chk("a_err", a_err, err_at[0] == cyc);
      chk("b_err", b_err, err_at[1] == cyc);
      chk("a_rdata", a_rdata, exp_rdata[0]);
      chk("b_rdata", b_rdata, exp_rdata[1]);
    end
    if (rst_v) begin
      if (chk_on) chk("mem_we_rst", mem_we, 0);
      last_b = 1;
      free_at = cyc + 1;
      rv_at = '{-1, -1};
      err_at = '{-1, -1};
      exp_rdata = '{8'h00, 8'h00};
      chk_on = 1;
    end else if (chk_on) begin
      busy = cyc < free_at;
      win = -1;
      if (!busy) begin
        if (ra && rb) win = last_b ? 0 : 1;
        else if (ra) win = 0;
        else if (rb) win = 1;
      end
      chk("a_gnt", a_gnt, win == 0);
      chk("b_gnt", b_gnt, win == 1);
      if (win >= 0) begin
        t = (win == 0) ? qa.pop_front() : qb.pop_front();
        if (win == 0) wait_c[0] = qa.size() > 0 ? qa[0].gap : 0;
        else          wait_c[1] = qb.size() > 0 ? qb[0].gap : 0;
        last_b = (win == 1);
        chk("mem_we", mem_we, t.we && in_win(t.addr));
        chk("mem_addr", mem_addr, t.addr);
        chk("mem_wdata", mem_wdata, t.wd);
        if (!in_win(t.addr)) err_at[win] = cyc + 1;
        else if (t.we) ref_mem[t.addr] = t.wd;
        else begin
          rv_at[win] = cyc + 2;
          rv_data[win] = ref_mem[t.addr];
          free_at = cyc + 2;
          rd_addr_m = t.addr;
        end
      end else begin
        chk("mem_we_idle", mem_we, 0);
        chk("mem_addr_idle", mem_addr, busy ? rd_addr_m : 8'h00);
      end
    end
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 2000) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 2000, 1);
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst_v = 1;
    step();
    rst_v = 0;
  endtask

  function automatic txn_t mk(input bit we, input logic [7:0] a,
                              input logic [7:0] d, input int g);
    txn_t t;
    t.we = we; t.addr = a; t.wd = d; t.gap = g;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) == 0)
      t.addr = $urandom_range(0, 1) ? 8'($urandom_range(0, 63))
                                    : 8'($urandom_range(128, 255));
    else
      t.addr = 8'($urandom_range(64, 127));
    t.wd = 8'($urandom);
    t.gap = $urandom_range(0, 3);
    return t;
  endfunction

  initial begin
    int ord;
    logic [7:0] m20, m128;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 13);
    wait_c = '{0, 0};
    rv_at = '{-1, -1};
    err_at = '{-1, -1};
    n_arv = 0; n_berr = 0; rva_cyc = -1;
    reset = 1; a_req = 0; b_req = 0;
    a_we = 0; a_addr = 0; a_wdata = 0;
    b_we = 0; b_addr = 0; b_wdata = 0;
    rst_v = 1;
    step();
    step();
    rst_v = 0;

    // A writes then reads back.
    qa.push_back(mk(1, 8'd66, 8'h5A, 0));
    qa.push_back(mk(0, 8'd66, 8'h00, 0));
    drain();
    chk("t1_a_rdata", a_rdata, 8'h5A);
    chk("t1_b_rdata", b_rdata, 8'h00);

    // Continuous contention from reset alternates with no gaps.
    do_reset();
    glog.delete(); gcyc.delete();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(1, 8'd70, 8'h11, 0));
      qb.push_back(mk(1, 8'd71, 8'h22, 0));
    end
    drain();
    ord = (glog.size() >= 4) ? glog[0] * 8 + glog[1] * 4 + glog[2] * 2
                                + glog[3] : -1;
    chk("t2_order", ord, 5);
    chk("t2_nogap", gcyc.size() >= 4 ? gcyc[3] - gcyc[0] : -1, 3);
    chk("t2_mem70", dev_mem[70], 8'h11);
    chk("t2_mem71", dev_mem[71], 8'h22);

    // B waits through A's read wait cycle.
    glog.delete(); gcyc.delete();
    qa.push_back(mk(0, 8'd80, 8'h00, 0));
    qb.push_back(mk(1, 8'd81, 8'h99, 0));
    drain();
    chk("t3_first_a", glog.size() >= 2 ? glog[0] : -1, 0);
    chk("t3_b_at_t2", gcyc.size() >= 2 ? gcyc[1] - gcyc[0] : -1, 2);
    chk("t3_rvalid_with_b", gcyc.size() >= 2 ? rva_cyc : -1,
        gcyc.size() >= 2 ? gcyc[1] : -2);

    // Out-of-window B writes leave memory alone.
    m20 = dev_mem[8'h20];
    m128 = dev_mem[128];
    n_berr = 0;
    qb.push_back(mk(1, 8'h20, 8'hEE, 0));
    qb.push_back(mk(1, 8'd128, 8'hEE, 0));
    drain();
    chk("t4_err_count", n_berr, 2);
    chk("t4_mem20", dev_mem[8'h20], m20);
    chk("t4_mem128", dev_mem[128], m128);

    // Reset during the read wait cycle abandons the read.
    glog.delete(); gcyc.delete();
    qa.push_back(mk(0, 8'd90, 8'h00, 0));
    for (int n = 0; n < 20 && glog.size() == 0; n++) step();
    chk("t5_granted", glog.size(), 1);
    n_arv = 0;
    do_reset();
    step();
    step();
    chk("t5_no_rvalid", n_arv, 0);
    chk("t5_a_rdata", a_rdata, 8'h00);
    glog.delete(); gcyc.delete();
    qb.push_back(mk(1, 8'd100, 8'h01, 0));
    qa.push_back(mk(1, 8'd101, 8'h02, 0));
    drain();
    chk("t5_first_a", glog.size() > 0 ? glog[0] : -1, 0);

    // Window boundaries are legal.
    qb.push_back(mk(1, 8'd127, 8'hC3, 0));
    qb.push_back(mk(1, 8'd64, 8'h3C, 0));
    qb.push_back(mk(0, 8'd127, 8'h00, 0));
    qb.push_back(mk(0, 8'd64, 8'h00, 0));
    drain();
    chk("t6_b_rdata", b_rdata, 8'h3C);
    chk("t6_mem127", dev_mem[127], 8'hC3);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (qa.size() < 2) qa.push_back(rnd_txn());
      if (qb.size() < 2) qb.push_back(rnd_txn());
      rst_v = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_v = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 8-bit data memory (window 64..127, 1-cycle registered read, write_enable gates read update).
- Requester A is the core load/store unit; requester B is the loader/debug port.
- Grants one access per arbitration using round-robin.
- Sequences the read-wait cycle, returns read data to the owning requester, and flags out-of-window addresses without touching memory.

Parameters:
- ADDR_W, 8, address width for requesters and memory.
- DATA_W, 8, data width.
- BASE, 64, lowest legal data address.
- DEPTH, 64, number of legal addresses; legal range is BASE..BASE+DEPTH-1.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- a_req  input  1  requester A access request, held until a_gnt
- a_we  input  1  A: 1=write, 0=read
- a_addr  input  ADDR_W  A address
- a_wdata  input  DATA_W  A write data
- a_gnt  output  1  A granted this cycle (1-cycle pulse)
- a_rvalid  output  1  A read data valid (1-cycle pulse)
- a_rdata  output  DATA_W  A read data, held until next A read completes
- a_err  output  1  A out-of-window access (1-cycle pulse)
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err  same as A, for requester B
- mem_addr  output  ADDR_W  to memory data_address
- mem_wdata  output  DATA_W  to memory write_data
- mem_we  output  1  to memory write_enable
- mem_rdata  input  DATA_W  from memory read_data

Behaviour:
- FSM states: IDLE, RD_WAIT.
- Reset (synchronous, active-high):
  - state=IDLE, last_grant=B, so A wins the first contention.
  - Registered outputs cleared: a/b_rvalid=0, a/b_err=0, a/b_rdata=0.
  - mem_we=0 while reset is high.
  - A read in flight is abandoned; no rvalid is produced.
- IDLE, no req:
  - gnt=0, mem_we=0, mem_addr/mem_wdata=0.
- IDLE, req present (combinational grant in the same cycle):
  - Only one requester asserts req: grant it.
  - Both assert req: grant the one not in last_grant. last_grant updates on every grant.
  - Winner's addr/wdata drive mem_addr/mem_wdata in the grant cycle.
- Legal write (BASE <= addr <= BASE+DEPTH-1):
  - mem_we=1 in the grant cycle only.
  - Memory updates at the end of the grant cycle.
  - FSM stays IDLE; the next grant can issue the next cycle.
- Legal read:
  - mem_we=0 in the grant cycle; memory samples at the end of the grant cycle (T).
  - FSM goes to RD_WAIT at T+1. mem_addr holds the read address; mem_we=0; no grants.
  - End of T+1: owner's rdata <= mem_rdata.
  - T+2: owner's rvalid=1 for one cycle; FSM is back in IDLE and a new grant is allowed in T+2.
  - Read throughput: one read per 2 cycles. Write throughput: one write per cycle.
- Out-of-window access (addr < BASE or addr > BASE+DEPTH-1):
  - gnt is still issued.
  - mem_we forced to 0 and memory state is unchanged.
  - err pulses at T+1; no rvalid; rdata is unchanged.
  - FSM stays IDLE.
  - Counts as a grant for round-robin purposes.
- Address arithmetic: range check uses unsigned compares at ADDR_W bits. BASE+DEPTH-1 = 127 with defaults; no wrap.
- Requester rules:
  - req, we, addr and wdata are stable while req=1 and gnt=0.
  - Requester may drop req in the cycle after gnt.
  - req still high in the cycle after gnt is a new request.
- Request arriving during RD_WAIT waits. It is arbitrated in the next IDLE cycle under normal round-robin.
- a_gnt and b_gnt are never high together.
- At most one of the rvalid/err outputs is high per requester per cycle.

Test Plan:
- Reset, then A writes 0x5A to 66 -> a_gnt=1 and mem_we=1 in cycle 0. A then reads 66 -> a_rvalid=1 at grant+2 with a_rdata=0x5A; b_* outputs all 0.
- A and B both request continuously from reset: A writes addr 70 data 0x11, B writes addr 71 data 0x22 -> grants alternate A, B, A, B with no gaps; memory holds 70=0x11, 71=0x22.
- A reads 80 while B requests in the same cycle -> a_gnt at T, B waits through RD_WAIT, b_gnt at T+2 coincident with a_rvalid.
- B writes to addr 0x20 and then to addr 128 -> b_gnt each time, mem_we stays 0, b_err pulses at T+1, and memory contents are unchanged on readback.
- A read granted, reset asserted during RD_WAIT -> no a_rvalid; a_rdata=0; state IDLE; first post-reset contention goes to A.
- B reads 127 (upper bound) and 64 (lower bound) -> both legal, b_rvalid with the stored values, no b_err.
